// File: rtl/alu_ctrl_pkg.sv
// Shared types for the ALU controller: ALU op codes, Funct7/Funct3 constants,
// M-extension FSM states and the base R/I-type op table.
package alu_ctrl_pkg;

    typedef enum logic [4:0] {
        ALU_AND  = 5'd0,
        ALU_OR   = 5'd1,
        ALU_ADD  = 5'd2,
        ALU_XOR  = 5'd3,
        ALU_SLL  = 5'd4,
        ALU_SUB  = 5'd6,
        ALU_SLTU = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SLT  = 5'd10,
        ALU_SRA  = 5'd12
    } alu_op_e;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {
        MD_IDLE,
        MD_MUL,
        MD_DIV,
        MD_DONE
    } md_state_e;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Funct7=0000000 meaning of each Funct3 (shared by R-type and OP-IMM)
    function automatic alu_op_e base_op(input logic [2:0] f3);
        case (f3)
            3'b000:  base_op = ALU_ADD;
            3'b001:  base_op = ALU_SLL;
            3'b010:  base_op = ALU_SLT;
            3'b011:  base_op = ALU_SLTU;
            3'b100:  base_op = ALU_XOR;
            3'b101:  base_op = ALU_SRL;
            3'b110:  base_op = ALU_OR;
            default: base_op = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/md_divider.sv
// Iterative restoring divider on operand magnitudes; one quotient bit per step,
// sign fix applied combinationally on the final step's result.
module md_divider #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_step,
    input  logic            i_last,
    input  logic            i_signed,
    input  logic            i_rem_sel,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    logic [XLEN-1:0] r_quot;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_dvs;
    logic            r_negq;
    logic            r_negr;
    logic            r_rem_sel;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN:0]   w_shift;
    logic [XLEN:0]   w_diff;
    logic            w_ge;
    logic [XLEN-1:0] w_rem_n;
    logic [XLEN-1:0] w_quot_n;

    assign w_a_neg  = i_signed & i_dividend[XLEN-1];
    assign w_b_neg  = i_signed & i_divisor[XLEN-1];

    assign w_shift  = {r_rem, r_quot[XLEN-1]};
    assign w_diff   = w_shift - {1'b0, r_dvs};
    assign w_ge     = ~w_diff[XLEN];
    assign w_rem_n  = w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    assign w_quot_n = {r_quot[XLEN-2:0], w_ge};

    assign o_done   = i_step & i_last;
    assign o_result = r_rem_sel ? (r_negr ? -w_rem_n : w_rem_n)
                                : (r_negq ? -w_quot_n : w_quot_n);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_quot    <= '0;
            r_rem     <= '0;
            r_dvs     <= '0;
            r_negq    <= 1'b0;
            r_negr    <= 1'b0;
            r_rem_sel <= 1'b0;
        end else if (i_start) begin
            r_quot    <= w_a_neg ? -i_dividend : i_dividend;
            r_rem     <= '0;
            r_dvs     <= w_b_neg ? -i_divisor : i_divisor;
            r_negq    <= w_a_neg ^ w_b_neg;
            r_negr    <= w_a_neg;
            r_rem_sel <= i_rem_sel;
        end else if (i_step) begin
            r_quot    <= w_quot_n;
            r_rem     <= w_rem_n;
        end
    end

endmodule

// File: rtl/alu_md_controller.sv
// ALU control decoder plus multi-cycle RV32M/RV64M unit that stalls the core
// until the registered M-extension result is available.
module alu_md_controller
    import alu_ctrl_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int MUL_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            valid,
    input  logic [1:0]      ALUOp,
    input  logic [6:0]      Funct7,
    input  logic [2:0]      Funct3,
    input  logic            Branch,
    input  logic            Mem,
    input  logic            OpI,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic [4:0]      Operation,
    output logic            Con_beq,
    output logic            Con_bne,
    output logic            Con_blt,
    output logic            Con_bge,
    output logic            Con_bltu,
    output logic            Con_bgeu,
    output logic            md_sel,
    output logic [XLEN-1:0] md_result,
    output logic            stall
);

    localparam int CW = $clog2(XLEN);

    alu_op_e           w_op;
    logic [5:0]        w_con;
    logic [6:0]        w_f7_sh;

    md_state_e         r_state;
    md_state_e         w_state_n;
    logic [CW-1:0]     r_cnt;
    logic [CW-1:0]     w_cnt_n;
    logic [XLEN-1:0]   r_md_result;
    logic [XLEN-1:0]   w_res_n;
    logic              w_res_load;
    logic [2*XLEN-1:0] r_pipe [MUL_LAT];
    logic              r_hi;

    logic              w_mop;
    logic              w_is_div;
    logic              w_sgn_a;
    logic              w_sgn_b;
    logic              w_hi;
    logic              w_rem;
    logic              w_b_zero;
    logic              w_ovf;
    logic [XLEN-1:0]   w_special;
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    logic [2*XLEN-1:0] w_prod;
    logic              w_div_start;
    logic              w_div_done;
    logic [XLEN-1:0]   w_div_result;

    // RV64 immediate shifts carry shamt[5] in Funct7[0]
    assign w_f7_sh = (XLEN == 64) ? {Funct7[6:1], 1'b0} : Funct7;

    always_comb begin
        w_op  = ALU_ADD;
        w_con = '0;
        if (Mem || (ALUOp == 2'b00 && !OpI)) begin
            w_op = ALU_ADD;
        end else if (Branch) begin
            case (Funct3)
                3'b000:  begin w_op = ALU_SUB;  w_con[0] = 1'b1; end
                3'b001:  begin w_op = ALU_SUB;  w_con[1] = 1'b1; end
                3'b100:  begin w_op = ALU_SLT;  w_con[2] = 1'b1; end
                3'b101:  begin w_op = ALU_SLT;  w_con[3] = 1'b1; end
                3'b110:  begin w_op = ALU_SLTU; w_con[4] = 1'b1; end
                3'b111:  begin w_op = ALU_SLTU; w_con[5] = 1'b1; end
                default: w_op = ALU_ADD;
            endcase
        end else if (OpI) begin
            if (Funct3 == 3'b001) begin
                if (w_f7_sh == F7_BASE) w_op = ALU_SLL;
            end else if (Funct3 == 3'b101) begin
                if (w_f7_sh == F7_BASE)     w_op = ALU_SRL;
                else if (w_f7_sh == F7_ALT) w_op = ALU_SRA;
            end else begin
                w_op = base_op(Funct3);
            end
        end else if (ALUOp == 2'b10) begin
            if (Funct7 == F7_BASE) begin
                w_op = base_op(Funct3);
            end else if (Funct7 == F7_ALT) begin
                if (Funct3 == 3'b000)      w_op = ALU_SUB;
                else if (Funct3 == 3'b101) w_op = ALU_SRA;
            end
        end
    end

    assign Operation = w_op;
    assign Con_beq   = w_con[0];
    assign Con_bne   = w_con[1];
    assign Con_blt   = w_con[2];
    assign Con_bge   = w_con[3];
    assign Con_bltu  = w_con[4];
    assign Con_bgeu  = w_con[5];

    always_comb begin
        w_is_div = 1'b0;
        w_sgn_a  = 1'b0;
        w_sgn_b  = 1'b0;
        w_hi     = 1'b1;
        w_rem    = 1'b0;
        case (Funct3)
            F3_MUL:    w_hi = 1'b0;
            F3_MULH:   begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            F3_MULHSU: w_sgn_a = 1'b1;
            F3_MULHU:  w_hi = 1'b1;
            F3_DIV:    begin w_is_div = 1'b1; w_sgn_a = 1'b1; end
            F3_DIVU:   w_is_div = 1'b1;
            F3_REM:    begin w_is_div = 1'b1; w_sgn_a = 1'b1; w_rem = 1'b1; end
            F3_REMU:   begin w_is_div = 1'b1; w_rem = 1'b1; end
            default:   w_hi = 1'b1;
        endcase
    end

    assign w_mop     = valid && ALUOp == 2'b10 && Funct7 == F7_MULDIV;
    assign w_b_zero  = (op_b == '0);
    assign w_ovf     = w_sgn_a && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
    assign w_special = w_rem ? (w_b_zero ? op_a : '0)
                             : (w_b_zero ? '1 : op_a);

    assign w_a_ext = {{XLEN{w_sgn_a & op_a[XLEN-1]}}, op_a};
    assign w_b_ext = {{XLEN{w_sgn_b & op_b[XLEN-1]}}, op_b};
    assign w_prod  = w_a_ext * w_b_ext;

    md_divider #(
        .XLEN(XLEN)
    ) u_div (
        .i_clk      (clk),
        .i_rst      (reset),
        .i_start    (w_div_start),
        .i_step     (r_state == MD_DIV),
        .i_last     (r_cnt == '0),
        .i_signed   (w_sgn_a),
        .i_rem_sel  (w_rem),
        .i_dividend (op_a),
        .i_divisor  (op_b),
        .o_done     (w_div_done),
        .o_result   (w_div_result)
    );

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_res_load  = 1'b0;
        w_res_n     = r_md_result;
        w_div_start = 1'b0;
        case (r_state)
            MD_IDLE: begin
                if (w_mop) begin
                    if (!w_is_div) begin
                        w_state_n = MD_MUL;
                        w_cnt_n   = CW'(MUL_LAT - 1);
                    end else if (w_b_zero || w_ovf) begin
                        w_state_n  = MD_DONE;
                        w_res_load = 1'b1;
                        w_res_n    = w_special;
                    end else begin
                        w_state_n   = MD_DIV;
                        w_cnt_n     = CW'(XLEN - 1);
                        w_div_start = 1'b1;
                    end
                end
            end
            MD_MUL: begin
                if (!valid) begin
                    w_state_n = MD_IDLE;
                end else if (r_cnt == '0) begin
                    w_state_n  = MD_DONE;
                    w_res_load = 1'b1;
                    w_res_n    = r_hi ? r_pipe[MUL_LAT-1][2*XLEN-1:XLEN]
                                      : r_pipe[MUL_LAT-1][XLEN-1:0];
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            MD_DIV: begin
                if (!valid) begin
                    w_state_n = MD_IDLE;
                end else if (w_div_done) begin
                    w_state_n  = MD_DONE;
                    w_res_load = 1'b1;
                    w_res_n    = w_div_result;
                end else begin
                    w_cnt_n = r_cnt - 1'b1;
                end
            end
            default: w_state_n = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Product is formed from the live operands at capture, then delayed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MUL_LAT; i++) r_pipe[i] <= '0;
            r_hi        <= 1'b0;
            r_md_result <= '0;
        end else begin
            if (r_state == MD_IDLE && w_mop && !w_is_div) begin
                r_pipe[0] <= w_prod;
                r_hi      <= w_hi;
            end
            if (r_state == MD_MUL) begin
                for (int i = 1; i < MUL_LAT; i++) r_pipe[i] <= r_pipe[i-1];
            end
            if (w_res_load) r_md_result <= w_res_n;
        end
    end

    assign md_result = r_md_result;
    assign md_sel    = w_mop;
    assign stall     = !reset && w_mop && (r_state != MD_DONE);

endmodule

// File: tb/tb_alu_md_controller.sv
// Bench for alu_md_controller: decode checks plus randomized M-extension ops
// compared with an arithmetic reference model.
module tb_alu_md_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid;
    logic [1:0]  ALUOp;
    logic [6:0]  Funct7;
    logic [2:0]  Funct3;
    logic        Branch, Mem, OpI;
    logic [31:0] op_a, op_b;
    logic [4:0]  Operation;
    logic        Con_beq, Con_bne, Con_blt, Con_bge, Con_bltu, Con_bgeu;
    logic        md_sel;
    logic [31:0] md_result;
    logic        stall;
    logic [5:0]  w_con;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign w_con = {Con_bgeu, Con_bltu, Con_bge, Con_blt, Con_bne, Con_beq};

    alu_md_controller #(
        .XLEN(32),
        .MUL_LAT(2)
    ) dut (
        .clk(clk), .reset(reset), .valid(valid), .ALUOp(ALUOp),
        .Funct7(Funct7), .Funct3(Funct3), .Branch(Branch), .Mem(Mem),
        .OpI(OpI), .op_a(op_a), .op_b(op_b), .Operation(Operation),
        .Con_beq(Con_beq), .Con_bne(Con_bne), .Con_blt(Con_blt),
        .Con_bge(Con_bge), .Con_bltu(Con_bltu), .Con_bgeu(Con_bgeu),
        .md_sel(md_sel), .md_result(md_result), .stall(stall)
    );

    function automatic void ref_decode(
        input logic [1:0] aluop, input logic [6:0] f7, input logic [2:0] f3,
        input logic br, input logic mem, input logic opi,
        output logic [4:0] op, output logic [5:0] con);
        logic [4:0] tbl [8];
        int idx;
        tbl = '{5'd2, 5'd4, 5'd10, 5'd7, 5'd3, 5'd8, 5'd1, 5'd0};
        op  = 5'd2;
        con = '0;
        if (mem || (aluop == 2'b00 && !opi)) return;
        if (br) begin
            if (f3 != 3'd2 && f3 != 3'd3) begin
                idx = (f3 < 3'd4) ? int'(f3) : int'(f3) - 2;
                con[idx] = 1'b1;
                op = (f3 < 3'd2) ? 5'd6 : (f3 < 3'd6) ? 5'd10 : 5'd7;
            end
            return;
        end
        if (opi) begin
            if (f3 == 3'd1)      op = (f7 == 7'h00) ? 5'd4 : 5'd2;
            else if (f3 == 3'd5) op = (f7 == 7'h00) ? 5'd8 : (f7 == 7'h20) ? 5'd12 : 5'd2;
            else                 op = tbl[f3];
            return;
        end
        if (aluop == 2'b10) begin
            if (f7 == 7'h00)      op = tbl[f3];
            else if (f7 == 7'h20) op = (f3 == 3'd0) ? 5'd6 : (f3 == 3'd5) ? 5'd12 : 5'd2;
        end
    endfunction

    function automatic logic [31:0] ref_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        p;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f3)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = longint'(sa) * longint'(sb); return p[63:32]; end
            3'd2: begin p = longint'(sa) * longint'({32'b0, b}); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                return sa / sb;
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                return sa % sb;
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int ref_cycles(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3 < 3'd4) return 1 + 2;
        if (b == 0) return 1;
        if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 1 + 32;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid  = 1'b0;
        ALUOp  = 2'b00;
        Funct7 = 7'h00;
        Funct3 = 3'd0;
        Branch = 1'b0;
        Mem    = 1'b0;
        OpI    = 1'b0;
    endtask

    task automatic set_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        valid  = 1'b1;
        ALUOp  = 2'b10;
        Funct7 = 7'b0000001;
        Funct3 = f3;
        Branch = 1'b0;
        Mem    = 1'b0;
        OpI    = 1'b0;
        op_a   = a;
        op_b   = b;
    endtask

    // Called just after a rising edge with the FSM idle; returns in the DONE cycle
    task automatic run_mop(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           output int cyc, output logic sel, output logic [31:0] res);
        set_mop(f3, a, b);
        #1;
        sel = md_sel;
        cyc = 0;
        while (stall === 1'b1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        res = md_result;
    endtask

    task automatic test_reset();
        idle_inputs();
        op_a  = '0;
        op_b  = '0;
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if (md_result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_md_result got=%h exp=%h", md_result, 32'h0);
        end
        n_checks++;
        if (Operation !== 5'd2) begin
            n_errors++;
            $display("FAIL reset_operation got=%0d exp=%0d", Operation, 2);
        end
        set_mop(3'd4, 32'd9, 32'd3);
        #1;
        n_checks++;
        if (stall !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_forces_stall_low got=%b exp=0", stall);
        end
        idle_inputs();
        step();
        reset = 1'b0;
        step();
    endtask

    task automatic test_decode_directed();
        idle_inputs();
        valid = 1'b1; ALUOp = 2'b10; Funct7 = 7'h20; Funct3 = 3'd0;
        #1;
        n_checks++;
        if (Operation !== 5'd6 || stall !== 1'b0 || md_sel !== 1'b0) begin
            n_errors++;
            $display("FAIL dec_sub got op=%0d stall=%b sel=%b exp op=6 stall=0 sel=0", Operation, stall, md_sel);
        end
        OpI = 1'b1; Funct3 = 3'd5;
        #1;
        n_checks++;
        if (Operation !== 5'd12) begin
            n_errors++;
            $display("FAIL dec_srai got=%0d exp=12", Operation);
        end
        idle_inputs();
        valid = 1'b1; Branch = 1'b1; ALUOp = 2'b01; Funct3 = 3'd6;
        #1;
        n_checks++;
        if (Operation !== 5'd7 || w_con !== 6'b010000) begin
            n_errors++;
            $display("FAIL dec_bltu got op=%0d con=%b exp op=7 con=010000", Operation, w_con);
        end
        idle_inputs();
        valid = 1'b1; Mem = 1'b1; ALUOp = 2'b10; Funct3 = 3'd4;
        #1;
        n_checks++;
        if (Operation !== 5'd2) begin
            n_errors++;
            $display("FAIL dec_mem got=%0d exp=2", Operation);
        end
        idle_inputs();
        #1;
    endtask

    task automatic test_decode_random();
        logic [4:0] e_op;
        logic [5:0] e_con;
        int cls;
        for (int i = 0; i < 200; i++) begin
            idle_inputs();
            cls    = $urandom_range(0, 4);
            Funct3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 3))
                0:       Funct7 = 7'h00;
                1:       Funct7 = 7'h20;
                2:       Funct7 = 7'h01;
                default: Funct7 = 7'($urandom);
            endcase
            case (cls)
                0:       begin Mem = 1'b1; ALUOp = 2'($urandom); OpI = 1'($urandom); end
                1:       ALUOp = 2'b00;
                2:       begin Branch = 1'b1; ALUOp = 2'b01; end
                3:       begin OpI = 1'b1; ALUOp = 2'($urandom); end
                default: ALUOp = 2'b10;
            endcase
            #1;
            ref_decode(ALUOp, Funct7, Funct3, Branch, Mem, OpI, e_op, e_con);
            n_checks++;
            if (Operation !== e_op || w_con !== e_con) begin
                n_errors++;
                $display("FAIL dec_rand[%0d] aluop=%b f7=%h f3=%0d br=%b mem=%b opi=%b got op=%0d con=%b exp op=%0d con=%b",
                         i, ALUOp, Funct7, Funct3, Branch, Mem, OpI, Operation, w_con, e_op, e_con);
            end
        end
        idle_inputs();
        step();
    endtask

    task automatic test_mul();
        int cyc;
        logic sel;
        logic [31:0] res;
        run_mop(3'd0, 32'd7, 32'hFFFF_FFFD, cyc, sel, res);
        n_checks++;
        if (res !== 32'hFFFF_FFEB || cyc != 3 || sel !== 1'b1) begin
            n_errors++;
            $display("FAIL mul_basic got res=%h cyc=%0d sel=%b exp res=ffffffeb cyc=3 sel=1", res, cyc, sel);
        end
        idle_inputs();
        step();
        run_mop(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc, sel, res);
        n_checks++;
        if (res !== 32'hFFFF_FFFE || cyc != 3) begin
            n_errors++;
            $display("FAIL mulhu got res=%h cyc=%0d exp res=fffffffe cyc=3", res, cyc);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_div();
        logic [2:0]  f3 [6];
        logic [31:0] a  [6];
        logic [31:0] b  [6];
        logic [31:0] e  [6];
        int          ec [6];
        int cyc;
        logic sel;
        logic [31:0] res;
        f3 = '{3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6};
        a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        b  = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        e  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
        ec = '{33, 33, 1, 1, 1, 1};
        for (int i = 0; i < 6; i++) begin
            run_mop(f3[i], a[i], b[i], cyc, sel, res);
            n_checks++;
            if (res !== e[i] || cyc != ec[i]) begin
                n_errors++;
                $display("FAIL div_dir[%0d] f3=%0d a=%h b=%h got res=%h cyc=%0d exp res=%h cyc=%0d",
                         i, f3[i], a[i], b[i], res, cyc, e[i], ec[i]);
            end
            idle_inputs();
            step();
        end
    endtask

    task automatic test_random_mops();
        logic [2:0]  f3;
        logic [31:0] a, b;
        int cyc;
        logic sel;
        logic [31:0] res;
        for (int i = 0; i < 24; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2:       b = 32'($urandom_range(1, 15));
                3:       b = -32'($urandom_range(1, 15));
                default: ;
            endcase
            run_mop(f3, a, b, cyc, sel, res);
            n_checks++;
            if (res !== ref_m(f3, a, b) || cyc != ref_cycles(f3, a, b)) begin
                n_errors++;
                $display("FAIL mop_rand[%0d] f3=%0d a=%h b=%h got res=%h cyc=%0d exp res=%h cyc=%0d",
                         i, f3, a, b, res, cyc, ref_m(f3, a, b), ref_cycles(f3, a, b));
            end
            idle_inputs();
            step();
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic sel;
        logic [31:0] res;
        run_mop(3'd5, 32'd1000, 32'd7, cyc, sel, res);
        n_checks++;
        if (res !== 32'd142 || cyc != 33) begin
            n_errors++;
            $display("FAIL b2b_first got res=%h cyc=%0d exp res=%h cyc=33", res, cyc, 32'd142);
        end
        step();
        run_mop(3'd1, 32'hFFFF_FFFE, 32'd3, cyc, sel, res);
        n_checks++;
        if (res !== 32'hFFFF_FFFF || cyc != 3) begin
            n_errors++;
            $display("FAIL b2b_second got res=%h cyc=%0d exp res=ffffffff cyc=3", res, cyc);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_abort_mul();
        int cyc;
        logic sel;
        logic [31:0] res;
        run_mop(3'd0, 32'd3, 32'd5, cyc, sel, res);
        idle_inputs();
        step();
        set_mop(3'd0, 32'd6, 32'd7);
        step();
        n_checks++;
        if (stall !== 1'b1) begin
            n_errors++;
            $display("FAIL abort_in_mul got stall=%b exp=1", stall);
        end
        valid = 1'b0;
        step();
        n_checks++;
        if (stall !== 1'b0 || md_result !== 32'd15) begin
            n_errors++;
            $display("FAIL abort_hold got stall=%b res=%h exp stall=0 res=%h", stall, md_result, 32'd15);
        end
        run_mop(3'd0, 32'd6, 32'd7, cyc, sel, res);
        n_checks++;
        if (res !== 32'd42 || cyc != 3) begin
            n_errors++;
            $display("FAIL abort_restart got res=%h cyc=%0d exp res=%h cyc=3", res, cyc, 32'd42);
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid_div();
        int cyc;
        logic sel;
        logic [31:0] res;
        set_mop(3'd4, 32'd100, 32'd7);
        for (int i = 0; i < 10; i++) step();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (stall !== 1'b0 || md_result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid_div got stall=%b res=%h exp stall=0 res=0", stall, md_result);
        end
        idle_inputs();
        step();
        reset = 1'b0;
        step();
        run_mop(3'd4, 32'd100, 32'd7, cyc, sel, res);
        n_checks++;
        if (res !== 32'd14 || cyc != 33) begin
            n_errors++;
            $display("FAIL reset_recover got res=%h cyc=%0d exp res=%h cyc=33", res, cyc, 32'd14);
        end
        idle_inputs();
        step();
    endtask

    initial begin
        test_reset();
        test_decode_directed();
        test_decode_random();
        test_mul();
        test_div();
        test_random_mops();
        test_back_to_back();
        test_abort_mul();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_md_controller.md
# alu_md_controller

Parametrised successor to the single-cycle ALU controller, sitting between decode and execute in the RISC-V core. It decodes ALUOp/Funct3/Funct7/Branch/Mem/OpI into a 5-bit ALU operation code and six branch-condition strobes. It also executes RV32M/RV64M instructions (MUL*, DIV*, REM*) in a multi-cycle unit, stalling the core until the result is ready.

## Interface
- XLEN, 32, datapath width (32 or 64)
- MUL_LAT, 2, multiplier pipeline cycles (1..4)

- clk  in  1  core clock
- reset  in  1  reset; one clock, asynchronous, active-high
- valid  in  1  instruction in execute is live (0 = bubble/flush)
- ALUOp  in  2  main-decoder ALU class (00 addr, 01 branch, 10 R-type)
- Funct7  in  7  instr[31:25]
- Funct3  in  3  instr[14:12]
- Branch, Mem, OpI  in  1 each  main-decoder qualifiers
- op_a, op_b  in  XLEN  rs1/rs2 operand values
- Operation  out  5  ALU op code, combinational
- Con_beq, Con_bne, Con_blt, Con_bge, Con_bltu, Con_bgeu  out  1 each  branch strobes, combinational
- md_sel  out  1  writeback takes md_result instead of the ALU result
- md_result  out  XLEN  M-extension result, registered
- stall  out  1  hold PC and the execute stage

## Operation
- Op codes: AND=0, OR=1, ADD=2, XOR=3, SLL=4, SUB=6, SLTU=7, SRL=8, SLT=10, SRA=12.
- Decode:
  - Mem or (ALUOp=00 and !OpI) → ADD.
  - Branch: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU. The matching Con_* is 1, all others 0.
  - OpI uses Funct3. Funct7 is examined only for shifts: SRAI needs 0100000.
  - R-type with Funct7 0000000 or 0100000 maps per RV32I.
  - Undefined combinations → ADD.
- M-op: valid & ALUOp=10 & Funct7=0000001. Funct3 encodes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU in order 000..111.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE, M-op seen: capture operands and the signed/unsigned flags.
    - MUL*: go to MUL and load cnt=MUL_LAT-1.
    - DIV*/REM* with divisor 0 or signed overflow: load the result and go straight to DONE.
    - Other DIV*/REM*: go to DIV and load cnt=XLEN-1.
  - MUL: full 2·XLEN product through a MUL_LAT-deep register pipe. At cnt=0, load the low or high half into md_result and go to DONE.
  - DIV: one restoring-division step per cycle on magnitudes. At cnt=0, apply the sign fix and go to DONE.
  - DONE: always return to IDLE next cycle.
- stall = valid & M-op & (state≠DONE). This includes the first cycle, which is combinational.
- md_sel = 1 whenever an M-op is decoded (state-independent).
- Special cases (XLEN=32):
  - Divide by 0: quotient = all-ones, remainder = dividend.
  - 0x80000000 / −1: quotient = 0x80000000, remainder = 0.
- Signs: quotient is negative when the operand signs differ. The remainder takes the dividend's sign.

## Timing
- Reset (asynchronous): state=IDLE, cnt=0, md_result=0, pipe regs=0. stall=0 is forced immediately.
- Stall cycles per op:
  - MUL*: 1+MUL_LAT.
  - DIV*/REM*: 1+XLEN.
  - Special-case divide: 1.
- The result is visible in DONE with stall=0, and the core advances on that edge.
- valid=0 in MUL or DIV aborts: next state IDLE, md_result unchanged.
- Back-to-back M-ops: the second op starts in IDLE on the cycle after DONE.
- Operands are ignored after capture. The core must hold them stable anyway.
- Reset asserted mid-operation: stall falls in the same cycle, and the op is discarded.

## Structure
- alu_ctrl_pkg holds:
  - the alu_op_e codes;
  - F7_BASE, F7_ALT and F7_MULDIV constants;
  - the md_state_e enum;
  - the M-op Funct3 constants.
- Sub-module md_divider is the iterative restoring divider. It takes start/signed/rem_sel and returns done/result.
- The multiplier and the decode logic stay inline in the top module.

## Test plan
- ALUOp=10, F7=0100000, F3=000 → Operation=6, stall=0, md_sel=0. With OpI=1, F7=0100000, F3=101 → Operation=12.
- Branch=1, ALUOp=01, F3=110 → Operation=7 and Con_bltu=1 with the other five strobes 0. Mem=1 → Operation=2.
- MUL 7×0xFFFFFFFD (MUL_LAT=2) → stall high 3 cycles, then md_result=0xFFFFFFEB. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 → stall 33 cycles, md_result=0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF.
- DIV 5/0 → stall 1 cycle, md_result=0xFFFFFFFF. REM 5/0 → 5. DIV 0x80000000/0xFFFFFFFF → 0x80000000, and REM → 0.
- reset raised 10 cycles into a DIV → stall=0 in the same cycle and md_result=0. valid dropped mid-MUL → IDLE next cycle and stall=0.
